// File: rtl/MIPS_pkg.sv
// Shared MIPS16 definitions: program loader FSM states and the instruction
// memory pad word.
package MIPS_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        FILL,
        HOLD,
        RUN,
        ERR
    } loader_state_t;

    localparam logic [15:0] NOP_WORD = 16'h0000;

endpackage

// File: rtl/loader_hold_timer.sv
// Loadable down-counter that times how long the core is held in reset after
// the instruction memory has been filled.
module loader_hold_timer #(
    parameter int RST_HOLD = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic en,
    output logic expire
);

    localparam int CNT_W = $clog2(RST_HOLD + 1);
    localparam logic [CNT_W-1:0] HOLD_VAL = CNT_W'(RST_HOLD);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [CNT_W-1:0] cnt;

    // Expiry is flagged on the last held cycle so the next state lands on
    // exactly RST_HOLD cycles after the load.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= HOLD_VAL;
        end else if (en && (cnt != '0)) begin
            cnt <= cnt - CNT_ONE;
        end
    end

    assign expire = en && (cnt == CNT_ONE);

endmodule

// File: rtl/imem_stream_loader.sv
// Streams a program into MIPS16 instruction memory from address 0, pads the
// remainder with NOPs, then holds the core in reset before releasing it.
module imem_stream_loader
    import MIPS_pkg::*;
#(
    parameter int ADDR_W   = 8,
    parameter int DATA_W   = 16,
    parameter int RST_HOLD = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_last,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [DATA_W-1:0] imem_wdata,
    output logic              core_rst,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;
    localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);

    loader_state_t     state, state_next;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              xfer, accept_start, hold_load, hold_expire;
    logic              we_d, s_ready_d, core_rst_d, busy_d, done_d, err_d;
    logic [ADDR_W-1:0] waddr_d;
    logic [DATA_W-1:0] wdata_d;

    assign xfer         = s_valid && s_ready;
    assign accept_start = start && ((state == IDLE) || (state == RUN) || (state == ERR));

    loader_hold_timer #(
        .RST_HOLD (RST_HOLD)
    ) u_hold_timer (
        .clk    (clk),
        .rst    (rst),
        .load   (hold_load),
        .en     (state == HOLD),
        .expire (hold_expire)
    );

    // State and all outputs are registered together; outputs are decoded
    // from the next state so they change on the same edge as the state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            addr_q     <= '0;
            s_ready    <= 1'b0;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= '0;
            core_rst   <= 1'b1;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
        end else begin
            state      <= state_next;
            addr_q     <= addr_d;
            s_ready    <= s_ready_d;
            imem_we    <= we_d;
            imem_addr  <= waddr_d;
            imem_wdata <= wdata_d;
            core_rst   <= core_rst_d;
            busy       <= busy_d;
            done       <= done_d;
            err        <= err_d;
        end
    end

    // A word landing on the top address either completes the image or
    // overflows it; only earlier last words need NOP padding.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE, RUN, ERR: if (start) state_next = LOAD;
            LOAD: begin
                if (xfer) begin
                    if (addr_q == LAST_ADDR) begin
                        state_next = s_last ? HOLD : ERR;
                    end else if (s_last) begin
                        state_next = FILL;
                    end
                end
            end
            FILL:    if (addr_q == LAST_ADDR) state_next = HOLD;
            HOLD:    if (hold_expire) state_next = RUN;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        we_d    = xfer || (state == FILL);
        waddr_d = imem_addr;
        wdata_d = imem_wdata;
        if (we_d) begin
            waddr_d = addr_q;
            wdata_d = xfer ? s_data : DATA_W'(NOP_WORD);
        end

        addr_d = addr_q;
        if (accept_start) begin
            addr_d = '0;
        end else if (we_d) begin
            addr_d = addr_q + ADDR_ONE;
        end

        s_ready_d  = (state_next == LOAD);
        core_rst_d = (state_next != RUN);
        busy_d     = (state_next == LOAD) || (state_next == FILL) || (state_next == HOLD);
        done_d     = (state_next == RUN);
        err_d      = (state_next == ERR);
        hold_load  = (state_next == HOLD) && (state != HOLD);
    end

endmodule

// File: tb/tb_imem_stream_loader.sv
// Scoreboard bench for imem_stream_loader: every accepted word and every
// expected pad write is queued and matched against the write port.
module tb_imem_stream_loader;

    localparam int ADDR_W   = 8;
    localparam int DATA_W   = 16;
    localparam int RST_HOLD = 4;
    localparam int DEPTH    = 1 << ADDR_W;

    logic              clk = 1'b0;
    logic              rst, start, s_valid, s_ready, s_last;
    logic [DATA_W-1:0] s_data, imem_wdata;
    logic              imem_we, core_rst, busy, done, err;
    logic [ADDR_W-1:0] imem_addr;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wr_t;

    wr_t               exp_q[$];
    wr_t               mon_e;
    logic [DATA_W-1:0] mem     [DEPTH];
    logic [DATA_W-1:0] exp_mem [DEPTH];
    logic [DATA_W-1:0] prog_words[$];
    logic [ADDR_W-1:0] next_addr;
    int                test_count = 0;
    int                fail_count = 0;
    int                accepted, cycles;

    imem_stream_loader #(
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .RST_HOLD (RST_HOLD)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .s_data     (s_data),
        .s_last     (s_last),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .core_rst   (core_rst),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        test_count++;
        if (observed !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    // Instruction memory model plus the write-port scoreboard.
    always @(posedge clk) begin
        if (imem_we) mem[imem_addr] <= imem_wdata;
    end

    always @(negedge clk) begin
        if (imem_we) begin
            if (exp_q.size() == 0) begin
                checkOutput("spurious_we_addr", 32'(imem_addr), 32'hFFFF_FFFF);
            end else begin
                mon_e = exp_q.pop_front();
                checkOutput("wr_addr", 32'(imem_addr), 32'(mon_e.addr));
                checkOutput("wr_data", 32'(imem_wdata), 32'(mon_e.data));
            end
        end
    end

    initial begin
        #300000;
        $display("[TB] FAIL watchdog: simulation time limit exceeded");
        $fatal(1, "[TB] watchdog");
    end

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic startSession(input bit reset_model);
        start = 1'b1;
        tick();
        start = 1'b0;
        if (reset_model) next_addr = '0;
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_core_rst"}, 32'(core_rst), 32'd1);
        checkOutput({tag, "_s_ready"}, 32'(s_ready), 32'd0);
        checkOutput({tag, "_imem_we"}, 32'(imem_we), 32'd0);
        checkOutput({tag, "_imem_addr"}, 32'(imem_addr), 32'd0);
        checkOutput({tag, "_imem_wdata"}, 32'(imem_wdata), 32'd0);
        checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
        checkOutput({tag, "_done"}, 32'(done), 32'd0);
        checkOutput({tag, "_err"}, 32'(err), 32'd0);
    endtask

    // Offers n words (from prog_words, else random); a word the DUT has not
    // taken within 10 cycles ends the stream.
    task automatic applyStimulus(input int n, input bit last_on_final, input bit gaps,
                                 output int taken);
        int                idle;
        bit                got;
        logic [DATA_W-1:0] word;
        taken = 0;
        for (int i = 0; i < n; i++) begin
            if (gaps) begin
                idle    = $urandom_range(0, 3);
                s_valid = 1'b0;
                s_data  = DATA_W'($urandom);
                s_last  = 1'($urandom_range(0, 1));
                if (idle > 0) tick(idle);
            end
            word    = (i < prog_words.size()) ? prog_words[i] : DATA_W'($urandom);
            s_valid = 1'b1;
            s_data  = word;
            s_last  = last_on_final && (i == n - 1);
            got     = 1'b0;
            for (int w = 0; w < 10 && !got; w++) begin
                @(negedge clk);
                if (s_ready) begin
                    got = 1'b1;
                    exp_q.push_back('{next_addr, word});
                    exp_mem[next_addr] = word;
                    if (s_last && (next_addr != ADDR_W'(DEPTH - 1))) begin
                        for (int a = int'(next_addr) + 1; a < DEPTH; a++) begin
                            exp_q.push_back('{ADDR_W'(a), MIPS_pkg::NOP_WORD});
                            exp_mem[a] = MIPS_pkg::NOP_WORD;
                        end
                    end
                    next_addr = next_addr + 1'b1;
                end
                @(posedge clk);
                #1;
            end
            if (!got) break;
            taken++;
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    // Counts cycles from the write of the top address to core_rst falling.
    task automatic waitRelease(output int count);
        bit seen;
        seen  = 1'b0;
        count = 0;
        for (int w = 0; w < 400 && !seen; w++) begin
            @(negedge clk);
            if (imem_we && (imem_addr == ADDR_W'(DEPTH - 1))) seen = 1'b1;
        end
        checkOutput("last_write_seen", 32'(seen), 32'd1);
        if (seen) begin
            while (core_rst && (count < 20)) begin
                @(negedge clk);
                count++;
                if (core_rst) checkOutput("hold_busy", 32'(busy), 32'd1);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic checkRunning(input string tag);
        checkOutput({tag, "_release_delay"}, 32'(cycles), 32'(RST_HOLD));
        checkOutput({tag, "_done"}, 32'(done), 32'd1);
        checkOutput({tag, "_core_rst"}, 32'(core_rst), 32'd0);
        checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
        checkOutput({tag, "_err"}, 32'(err), 32'd0);
        checkOutput({tag, "_queue_drained"}, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic checkImage();
        for (int a = 0; a < DEPTH; a++) begin
            checkOutput($sformatf("imem[%0d]", a), 32'(mem[a]), 32'(exp_mem[a]));
        end
    endtask

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        s_valid   = 1'b0;
        s_data    = '0;
        s_last    = 1'b0;
        next_addr = '0;
        #12;
        checkResetValues("reset");
        tick();
        rst = 1'b0;
        tick(2);

        // Three-word program with padding.
        startSession(1'b1);
        checkOutput("t1_ready_after_start", 32'(s_ready), 32'd1);
        checkOutput("t1_busy_after_start", 32'(busy), 32'd1);
        checkOutput("t1_core_rst_loading", 32'(core_rst), 32'd1);
        prog_words = '{16'h1234, 16'h5678, 16'hABCD};
        applyStimulus(3, 1'b1, 1'b0, accepted);
        prog_words.delete();
        checkOutput("t1_accepted", 32'(accepted), 32'd3);
        checkOutput("t1_ready_drop", 32'(s_ready), 32'd0);
        s_valid = 1'b1;
        s_data  = 16'hDEAD;
        tick();
        s_valid = 1'b0;
        waitRelease(cycles);
        checkRunning("t1");
        checkImage();

        // Reload from RUN with random gaps in s_valid.
        startSession(1'b1);
        checkOutput("t2_core_rst", 32'(core_rst), 32'd1);
        checkOutput("t2_done", 32'(done), 32'd0);
        checkOutput("t2_ready", 32'(s_ready), 32'd1);
        applyStimulus(20, 1'b1, 1'b1, accepted);
        checkOutput("t2_accepted", 32'(accepted), 32'd20);
        waitRelease(cycles);
        checkRunning("t2");
        checkImage();

        // Exact fit: the last word lands on the top address, no padding.
        startSession(1'b1);
        applyStimulus(DEPTH, 1'b1, 1'b0, accepted);
        checkOutput("t3_accepted", 32'(accepted), 32'(DEPTH));
        checkOutput("t3_ready_drop", 32'(s_ready), 32'd0);
        checkOutput("t3_busy_hold", 32'(busy), 32'd1);
        checkOutput("t3_err", 32'(err), 32'd0);
        waitRelease(cycles);
        checkRunning("t3");
        checkImage();

        // Overflow: no last word within the memory depth.
        startSession(1'b1);
        applyStimulus(DEPTH + 1, 1'b0, 1'b0, accepted);
        checkOutput("t4_accepted", 32'(accepted), 32'(DEPTH));
        checkOutput("t4_err", 32'(err), 32'd1);
        checkOutput("t4_ready", 32'(s_ready), 32'd0);
        checkOutput("t4_core_rst", 32'(core_rst), 32'd1);
        checkOutput("t4_done", 32'(done), 32'd0);
        checkOutput("t4_busy", 32'(busy), 32'd0);
        checkOutput("t4_queue_drained", 32'(exp_q.size()), 32'd0);
        startSession(1'b1);
        checkOutput("t4_err_cleared", 32'(err), 32'd0);
        checkOutput("t4_ready_again", 32'(s_ready), 32'd1);
        applyStimulus(3, 1'b1, 1'b1, accepted);
        checkOutput("t4_reload_accepted", 32'(accepted), 32'd3);
        waitRelease(cycles);
        checkRunning("t4");
        checkImage();

        // Start ignored mid-load, then reset mid-load.
        startSession(1'b1);
        applyStimulus(1, 1'b0, 1'b0, accepted);
        startSession(1'b0);
        checkOutput("t5_ready_after_ignored_start", 32'(s_ready), 32'd1);
        applyStimulus(1, 1'b0, 1'b0, accepted);
        checkOutput("t5_second_accepted", 32'(accepted), 32'd1);
        tick();
        rst = 1'b1;
        #1;
        checkResetValues("t5_mid_reset");
        tick();
        rst = 1'b0;
        checkOutput("t5_queue_drained", 32'(exp_q.size()), 32'd0);
        s_valid = 1'b1;
        s_data  = 16'hBEEF;
        for (int i = 0; i < 5; i++) begin
            tick();
            checkOutput("t5_idle_ready", 32'(s_ready), 32'd0);
        end
        s_valid = 1'b0;
        startSession(1'b1);
        applyStimulus(4, 1'b1, 1'b1, accepted);
        checkOutput("t5_accepted", 32'(accepted), 32'd4);
        waitRelease(cycles);
        checkRunning("t5");
        checkImage();

        $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
        $finish;
    end

endmodule
